// File: rtl/ram_master_pkg.sv
// Shared definitions for the RV32I load/store RAM master:
// widths, funct3 width codes, FSM states and request legality.
package ram_master_pkg;

  localparam int MEM_W      = 32;
  localparam int MEM_ADDR_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    RMW_RD,
    RMW_WR,
    RESP
  } state_t;

  function automatic logic req_err(
    input logic       we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic bad;
    bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    if (f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
    if (f3[1:0] == 2'b10 && a != 2'b00) bad = 1'b1;
    if (we && f3[2]) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/ram_master_lsu_align.sv
// Byte/halfword lane extraction with sign/zero extension for loads,
// and lane merge of store data into a fetched word for sub-word stores.
module lsu_align
  import ram_master_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] ldata,
  output logic [31:0] mdata
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    ldata = {{24{b[7]}}, b};
      F3_BU:   ldata = {24'b0, b};
      F3_H:    ldata = {{16{h[15]}}, h};
      F3_HU:   ldata = {16'b0, h};
      F3_W:    ldata = word;
      default: ldata = '0;
    endcase
  end

  // Untouched lanes keep the fetched word.
  always_comb begin
    mdata = word;
    case (funct3[1:0])
      2'b00: mdata[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) mdata[31:16] = wdata[15:0];
        else         mdata[15:0]  = wdata[15:0];
      end
      default: mdata = wdata;
    endcase
  end

endmodule

// File: rtl/ram_master.sv
// RV32I load/store unit front-end driving a single-cycle RAM,
// with read-modify-write for byte and halfword stores.
module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DATA_W = MEM_W
) (
  input  logic              clk_100MHz,
  input  logic              arst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              r_ena_o,
  output logic [ADDR_W-1:0] r_addr_o,
  input  logic [DATA_W-1:0] r_data_i,
  output logic              w_ena_o,
  output logic [ADDR_W-1:0] w_addr_o,
  output logic [DATA_W-1:0] w_data_o
);

  state_t state, nstate;

  logic              we_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] rdata_q;

  logic              accept;
  logic              bad;
  logic              go_err, go_ld, go_sw, go_rmw;
  logic [ADDR_W-1:0] aligned;
  logic [DATA_W-1:0] lsu_word;
  logic [DATA_W-1:0] ldata;
  logic [DATA_W-1:0] mdata;

  assign req_ready_o = (state == IDLE) && !arst;
  assign accept      = req_valid_i && req_ready_o;
  assign bad         = req_err(req_we_i, req_funct3_i, req_addr_i[1:0]);
  assign go_err      = bad;
  assign go_ld       = !bad && !req_we_i;
  assign go_sw       = !bad && req_we_i && (req_funct3_i == F3_W);
  assign go_rmw      = !bad && req_we_i && (req_funct3_i != F3_W);
  assign aligned     = {addr_q[ADDR_W-1:2], 2'b00};
  // Loads extract straight from the RAM; RMW merges into the held word.
  assign lsu_word    = (state == LOAD) ? r_data_i : word_q;

  lsu_align u_align (
    .funct3 (f3_q),
    .lane   (addr_q[1:0]),
    .word   (lsu_word),
    .wdata  (wdata_q),
    .ldata  (ldata),
    .mdata  (mdata)
  );

  always_ff @(posedge clk_100MHz or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
    end else begin
      state <= nstate;
      if (accept) begin
        we_q    <= req_we_i;
        f3_q    <= req_funct3_i;
        addr_q  <= req_addr_i;
        wdata_q <= req_wdata_i;
        word_q  <= '0;
        rdata_q <= '0;
      end
      if (state == LOAD)   rdata_q <= ldata;
      if (state == RMW_RD) word_q  <= r_data_i;
    end
  end

  always_comb begin
    nstate      = state;
    rsp_valid_o = 1'b0;
    rsp_rdata_o = '0;
    rsp_err_o   = 1'b0;
    r_ena_o     = 1'b0;
    r_addr_o    = '0;
    w_ena_o     = 1'b0;
    w_addr_o    = '0;
    w_data_o    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            go_err: nstate = RESP;
            go_ld:  nstate = LOAD;
            go_sw:  nstate = STORE;
            go_rmw: nstate = RMW_RD;
            default: nstate = IDLE;
          endcase
        end
      end
      LOAD: begin
        r_ena_o  = 1'b1;
        r_addr_o = aligned;
        nstate   = RESP;
      end
      STORE: begin
        w_ena_o  = 1'b1;
        w_addr_o = aligned;
        w_data_o = wdata_q;
        nstate   = RESP;
      end
      RMW_RD: begin
        r_ena_o  = 1'b1;
        r_addr_o = aligned;
        nstate   = RMW_WR;
      end
      RMW_WR: begin
        w_ena_o  = 1'b1;
        w_addr_o = aligned;
        w_data_o = mdata;
        nstate   = RESP;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_rdata_o = rdata_q;
        rsp_err_o   = req_err(we_q, f3_q, addr_q[1:0]);
        nstate      = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ram_master.sv
// Scoreboard bench for ram_master: directed requests push expected
// responses; a negedge monitor pops and checks them against the DUT.
module tb_ram_master;

  logic        clk_100MHz = 1'b0;
  logic        arst = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        r_ena_o;
  logic [31:0] r_addr_o;
  logic [31:0] r_data_i;
  logic        w_ena_o;
  logic [31:0] w_addr_o;
  logic [31:0] w_data_o;

  ram_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_100MHz   (clk_100MHz),
    .arst         (arst),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_we_i     (req_we_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_err_o    (rsp_err_o),
    .r_ena_o      (r_ena_o),
    .r_addr_o     (r_addr_o),
    .r_data_i     (r_data_i),
    .w_ena_o      (w_ena_o),
    .w_addr_o     (w_addr_o),
    .w_data_o     (w_data_o)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  int cyc = 0;
  always @(posedge clk_100MHz) cyc <= cyc + 1;

  // Single-cycle RAM model, 64 words.
  logic [31:0] mem [0:63];
  always @(posedge clk_100MHz) if (w_ena_o) mem[w_addr_o[7:2]] <= w_data_o;
  assign r_data_i = mem[r_addr_o[7:2]];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int last_r_cyc = 0;
  int last_w_cyc = 0;
  int ena_cnt = 0;
  logic [31:0] last_w_data = '0;

  initial begin
    forever begin
      @(negedge clk_100MHz);
      if (r_ena_o) begin last_r_cyc = cyc; ena_cnt++; end
      if (w_ena_o) begin last_w_cyc = cyc; last_w_data = w_data_o; ena_cnt++; end
      tests++;
      if ((r_ena_o && w_ena_o) ||
          (!rsp_valid_o && (rsp_rdata_o != 0 || rsp_err_o)) ||
          (!r_ena_o && r_addr_o != 0) ||
          (r_ena_o && r_addr_o[1:0] != 0) ||
          (!w_ena_o && (w_addr_o != 0 || w_data_o != 0))) begin
        fails++;
        $display("FAIL invariant cyc=%0d r_ena=%b w_ena=%b r_addr=%h w_addr=%h w_data=%h rsp_v=%b rdata=%h err=%b required idle-zero/exclusive",
                 cyc, r_ena_o, w_ena_o, r_addr_o, w_addr_o, w_data_o,
                 rsp_valid_o, rsp_rdata_o, rsp_err_o);
      end
      if (rsp_valid_o) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp cyc=%0d rdata=%h err=%b required no response",
                   cyc, rsp_rdata_o, rsp_err_o);
        end else begin
          exp_t e;
          int lat;
          e = sb.pop_front();
          lat = cyc - e.acc + 1;
          if (rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || lat != e.lat) begin
            fails++;
            $display("FAIL rsp id=%0d got rdata=%h err=%b lat=%0d required rdata=%h err=%b lat=%0d",
                     e.id, rsp_rdata_o, rsp_err_o, lat, e.rdata, e.err, e.lat);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h required %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic issue(
    input  logic        we,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    input  logic [31:0] er,
    input  logic        ee,
    input  int          lat,
    input  int          id,
    input  logic        push,
    output int          acc
  );
    int n;
    n = 0;
    req_valid_i  = 1'b1;
    req_we_i     = we;
    req_funct3_i = f3;
    req_addr_i   = a;
    req_wdata_i  = wd;
    while (!req_ready_o && n < 50) begin
      @(negedge clk_100MHz);
      n++;
    end
    tests++;
    if (!req_ready_o) begin
      fails++;
      $display("FAIL accept_timeout id=%0d got ready=0 required ready=1", id);
      acc = -1;
    end else begin
      acc = cyc + 1;
      if (push) sb.push_back('{er, ee, acc, lat, id});
    end
    @(negedge clk_100MHz);
  endtask

  task automatic idle(input int n);
    req_valid_i = 1'b0;
    repeat (n) @(negedge clk_100MHz);
  endtask

  int a1, a2, e0, n;

  initial begin
    repeat (3) @(negedge clk_100MHz);
    chk("reset_ready", 32'(req_ready_o), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
    chk("reset_r_ena", 32'(r_ena_o), 32'd0);
    chk("reset_w_ena", 32'(w_ena_o), 32'd0);
    arst = 1'b0;
    #1 chk("ready_after_release", 32'(req_ready_o), 32'd1);
    @(negedge clk_100MHz);

    // Preload through the DUT itself.
    issue(1, 3'b010, 32'h10, 32'h8899_AABB, 0, 0, 2, 1, 1, a1);
    issue(1, 3'b010, 32'h20, 32'h0000_0000, 0, 0, 2, 2, 1, a1);
    issue(1, 3'b010, 32'h04, 32'h1122_3344, 0, 0, 2, 3, 1, a1);
    idle(1);

    issue(0, 3'b000, 32'h12, 0, 32'hFFFF_FF99, 0, 2, 4, 1, a1);
    issue(0, 3'b101, 32'h12, 0, 32'h0000_8899, 0, 2, 5, 1, a1);
    issue(0, 3'b001, 32'h10, 0, 32'hFFFF_AABB, 0, 2, 6, 1, a1);
    issue(0, 3'b100, 32'h13, 0, 32'h0000_0088, 0, 2, 7, 1, a1);
    issue(0, 3'b010, 32'h10, 0, 32'h8899_AABB, 0, 2, 8, 1, a1);

    issue(1, 3'b000, 32'h11, 32'h1234_5677, 0, 0, 3, 9, 1, a1);
    idle(5);
    chk("sb_merge_wdata", last_w_data, 32'h8899_77BB);
    chk("sb_rd_then_wr", 32'(last_w_cyc - last_r_cyc), 32'd1);
    issue(0, 3'b010, 32'h10, 0, 32'h8899_77BB, 0, 2, 10, 1, a1);
    idle(4);

    e0 = ena_cnt;
    issue(0, 3'b010, 32'h22, 0, 0, 1, 1, 11, 1, a1);
    issue(0, 3'b001, 32'h11, 0, 0, 1, 1, 12, 1, a1);
    issue(0, 3'b011, 32'h00, 0, 0, 1, 1, 13, 1, a1);
    issue(1, 3'b100, 32'h00, 32'hFF, 0, 1, 1, 14, 1, a1);
    issue(1, 3'b001, 32'h03, 32'hFF, 0, 1, 1, 15, 1, a1);
    idle(3);
    chk("err_no_ram_access", 32'(ena_cnt - e0), 32'd0);

    // Reset while the SW is in STORE: write must be abandoned.
    issue(1, 3'b010, 32'h20, 32'hDEAD_BEEF, 0, 0, 2, 16, 0, a1);
    req_valid_i = 1'b0;
    chk("store_w_ena", 32'(w_ena_o), 32'd1);
    chk("store_w_addr", w_addr_o, 32'h20);
    chk("store_w_data", w_data_o, 32'hDEAD_BEEF);
    arst = 1'b1;
    #1;
    chk("abort_w_ena", 32'(w_ena_o), 32'd0);
    chk("abort_ready", 32'(req_ready_o), 32'd0);
    repeat (3) @(negedge clk_100MHz);
    chk("abort_no_write", mem[8], 32'h0);
    arst = 1'b0;
    #1 chk("ready_after_abort", 32'(req_ready_o), 32'd1);
    @(negedge clk_100MHz);

    // Back-to-back with valid held high across busy states.
    issue(1, 3'b001, 32'h04, 32'hABCD_CAFE, 0, 0, 3, 17, 1, a1);
    issue(0, 3'b010, 32'h04, 0, 32'h1122_CAFE, 0, 2, 18, 1, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd4);
    issue(1, 3'b001, 32'h06, 32'h0000_BEEF, 0, 0, 3, 19, 1, a1);
    issue(0, 3'b010, 32'h04, 0, 32'hBEEF_CAFE, 0, 2, 20, 1, a2);
    idle(1);

    n = 0;
    while (sb.size() > 0 && n < 50) begin
      @(negedge clk_100MHz);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
